// File: rtl/fadd_arbiter_if.sv
// ----------------------------------------------------------------------------
// fadd_arbiter_if
// Bundles every signal that crosses the fadd_arbiter boundary apart from the
// clock and reset.
//   Requester side : req_valid, req_a, req_b (in)
//                    rsp_valid, rsp_data, rsp_err (out)
//   Status         : grant_id, arb_busy (out)
//   fadd side      : fpu_en, fpu_a, fpu_b (out)
//                    fpu_result, fpu_done, fpu_busy (in)
// The master modport is the arbiter's view. The slave modport is the view of
// the requesters and the fadd unit together.
// ----------------------------------------------------------------------------
interface fadd_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic [NREQ-1:0]    rsp_valid;
   logic [31:0]        rsp_data;
   logic               rsp_err;
   logic [IDW-1:0]     grant_id;
   logic               arb_busy;
   logic               fpu_en;
   logic [31:0]        fpu_a;
   logic [31:0]        fpu_b;
   logic [31:0]        fpu_result;
   logic               fpu_done;
   logic               fpu_busy;

   modport master (
      input  req_valid, req_a, req_b, fpu_result, fpu_done, fpu_busy,
      output rsp_valid, rsp_data, rsp_err, grant_id, arb_busy,
             fpu_en, fpu_a, fpu_b
   );

   modport slave (
      output req_valid, req_a, req_b, fpu_result, fpu_done, fpu_busy,
      input  rsp_valid, rsp_data, rsp_err, grant_id, arb_busy,
             fpu_en, fpu_a, fpu_b
   );
endinterface

// File: rtl/fadd_arbiter.sv
// ----------------------------------------------------------------------------
// fadd_arbiter
// Shares a single multi-cycle fadd unit among NREQ requesters. Arbitration is
// round-robin, and only one operation is in flight at a time. The winner's
// operands are latched and issued. When the adder reports done, the result
// goes back to that requester with a one-cycle valid pulse. If done never
// arrives, a watchdog returns an error response instead.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fadd_arbiter_if.master. It carries the requests, the responses,
//          grant_id, arb_busy and the fadd handshake. All outputs are
//          registered.
// ----------------------------------------------------------------------------
module fadd_arbiter #(
   parameter int NREQ    = 4,
   parameter int IDW     = $clog2(NREQ),
   parameter int TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           rst,
   fadd_arbiter_if.master bus
);

   // TIMEOUT is at least 8, so TIMEOUT-1 always fits in $clog2(TIMEOUT) bits.
   localparam int WDW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          r_state, w_nextState;
   logic [IDW-1:0]  r_last, w_last;
   logic [IDW-1:0]  r_grantId, w_grantId;
   logic [WDW-1:0]  r_wdog, w_wdog;
   logic [NREQ-1:0] r_rspValid, w_rspValid;
   logic [31:0]     r_rspData, w_rspData;
   logic            r_rspErr, w_rspErr;
   logic            r_fpuEn, w_fpuEn;
   logic [31:0]     r_fpuA, w_fpuA;
   logic [31:0]     r_fpuB, w_fpuB;
   logic            r_arbBusy, w_arbBusy;

   logic            w_found;
   logic [IDW-1:0]  w_winner;
   logic [IDW-1:0]  w_idx;

   // Round-robin search. The scan starts one past the last served requester
   // and wraps modulo NREQ. The first asserted request it meets wins. The
   // requester that was just served is therefore checked last, so it yields
   // to anyone else who is waiting.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = IDW'((int'(r_last) + k) % NREQ);
         if (!w_found && bus.req_valid[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   // Next-state logic and next values for every registered output. Each
   // signal holds its value unless a state explicitly changes it. This is how
   // rsp_data keeps the last result between responses.
   always_comb begin
      w_nextState = r_state;
      w_last      = r_last;
      w_grantId   = r_grantId;
      w_wdog      = r_wdog;
      w_rspValid  = r_rspValid;
      w_rspData   = r_rspData;
      w_rspErr    = r_rspErr;
      w_fpuEn     = r_fpuEn;
      w_fpuA      = r_fpuA;
      w_fpuB      = r_fpuB;
      w_arbBusy   = r_arbBusy;

      case (r_state)
         IDLE: begin
            if (w_found && !bus.fpu_busy) begin
               w_grantId   = w_winner;
               w_fpuA      = bus.req_a[{w_winner, 5'b0} +: 32];
               w_fpuB      = bus.req_b[{w_winner, 5'b0} +: 32];
               w_fpuEn     = 1'b1;
               w_arbBusy   = 1'b1;
               w_nextState = ISSUE;
            end
         end
         ISSUE: begin
            w_fpuEn     = 1'b0;
            w_wdog      = '0;
            w_nextState = WAIT;
         end
         WAIT: begin
            if (bus.fpu_done) begin
               w_rspData            = bus.fpu_result;
               w_rspErr             = 1'b0;
               w_rspValid           = '0;
               w_rspValid[r_grantId] = 1'b1;
               w_nextState          = RESP;
            end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
               w_rspData            = '0;
               w_rspErr             = 1'b1;
               w_rspValid           = '0;
               w_rspValid[r_grantId] = 1'b1;
               w_nextState          = RESP;
            end else begin
               w_wdog = r_wdog + 1'b1;
            end
         end
         RESP: begin
            // No arbitration happens here. The served requester is still
            // holding req_valid this cycle, so granting now could issue it
            // twice.
            w_rspValid  = '0;
            w_rspErr    = 1'b0;
            w_last      = r_grantId;
            w_arbBusy   = 1'b0;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State and output registers. Reset drops any in-flight operation without
   // sending a response. r_last starts at NREQ-1 so that requester 0 has
   // first priority after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_last     <= IDW'(NREQ - 1);
         r_grantId  <= '0;
         r_wdog     <= '0;
         r_rspValid <= '0;
         r_rspData  <= '0;
         r_rspErr   <= 1'b0;
         r_fpuEn    <= 1'b0;
         r_fpuA     <= '0;
         r_fpuB     <= '0;
         r_arbBusy  <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_last     <= w_last;
         r_grantId  <= w_grantId;
         r_wdog     <= w_wdog;
         r_rspValid <= w_rspValid;
         r_rspData  <= w_rspData;
         r_rspErr   <= w_rspErr;
         r_fpuEn    <= w_fpuEn;
         r_fpuA     <= w_fpuA;
         r_fpuB     <= w_fpuB;
         r_arbBusy  <= w_arbBusy;
      end
   end

   assign bus.rsp_valid = r_rspValid;
   assign bus.rsp_data  = r_rspData;
   assign bus.rsp_err   = r_rspErr;
   assign bus.grant_id  = r_grantId;
   assign bus.arb_busy  = r_arbBusy;
   assign bus.fpu_en    = r_fpuEn;
   assign bus.fpu_a     = r_fpuA;
   assign bus.fpu_b     = r_fpuB;

endmodule

// File: tb/tb_fadd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fadd_arbiter
// Testbench for fadd_arbiter. It contains a behavioural fadd model with a
// 4-cycle issue-to-done latency. The model's sums come from a table of
// hand-computed IEEE-754 results.
// ----------------------------------------------------------------------------
module tb_fadd_arbiter;

   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst;

   int compared   = 0;
   int mismatched = 0;

   logic        forceBusy, forceDone, suppressDone;
   logic        modelDone, modelBusy;
   logic [31:0] modelResult, latA, latB;
   int          modelCnt;

   fadd_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus();

   fadd_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Table of hand-computed single-precision sums. Any pair that is not in
   // the table returns a marker value.
   function automatic logic [31:0] fakeAdd(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h40400000;
         {32'h40000000, 32'h40000000}: return 32'h40800000;
         {32'h3FC00000, 32'h40200000}: return 32'h40800000;
         {32'h40400000, 32'h40800000}: return 32'h40E00000;
         {32'h3F000000, 32'h3E800000}: return 32'h3F400000;
         {32'h3F800000, 32'hC0400000}: return 32'hC0000000;
         {32'h41200000, 32'h40C00000}: return 32'h41800000;
         default:                      return 32'h7FC0BAD0;
      endcase
   endfunction

   // fadd model. It samples fpu_en, stays busy, and pulses done on the
   // fourth edge after the issue pulse. It is reset together with the
   // arbiter.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         modelCnt    <= 0;
         modelDone   <= 1'b0;
         modelBusy   <= 1'b0;
         modelResult <= '0;
         latA        <= '0;
         latB        <= '0;
      end else begin
         modelDone <= 1'b0;
         if (bus.fpu_en) begin
            modelCnt  <= 3;
            modelBusy <= 1'b1;
            latA      <= bus.fpu_a;
            latB      <= bus.fpu_b;
         end else if (modelCnt > 0) begin
            modelCnt <= modelCnt - 1;
            if (modelCnt == 1) begin
               modelDone   <= !suppressDone;
               modelBusy   <= 1'b0;
               modelResult <= fakeAdd(latA, latB);
            end
         end
      end
   end

   assign bus.fpu_done   = modelDone | forceDone;
   assign bus.fpu_busy   = modelBusy | forceBusy;
   assign bus.fpu_result = forceDone ? 32'hDEADBEEF : modelResult;

   // Global time limit, so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish, got running expected finished");
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b);
      bus.req_a[32*idx +: 32] = a;
      bus.req_b[32*idx +: 32] = b;
      bus.req_valid[idx]      = 1'b1;
   endtask

   // Waits one negedge at a time until a response appears or the limit runs
   // out. Running out of the limit counts as a failed comparison.
   task automatic waitRsp(input int limit, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (bus.rsp_valid == '0 && cycles < limit);
      checkOutput("rsp_seen", 32'(bus.rsp_valid != '0), 32'd1);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      checkOutput({tag, "_rsp_data"},  bus.rsp_data,       32'd0);
      checkOutput({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
      checkOutput({tag, "_fpu_en"},    32'(bus.fpu_en),    32'd0);
      checkOutput({tag, "_fpu_a"},     bus.fpu_a,          32'd0);
      checkOutput({tag, "_fpu_b"},     bus.fpu_b,          32'd0);
      checkOutput({tag, "_grant_id"},  32'(bus.grant_id),  32'd0);
      checkOutput({tag, "_arb_busy"},  32'(bus.arb_busy),  32'd0);
   endtask

   task automatic doReset();
      @(negedge clk);
      bus.req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      int          idx;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int cyc;
      bit ok;
      logic [31:0] opA[4];
      logic [31:0] opB[4];
      logic [31:0] expSum[4];

      vecs[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000};
      vecs[1] = '{1, 32'h40000000, 32'h40000000, 32'h40800000};
      vecs[2] = '{3, 32'h3FC00000, 32'h40200000, 32'h40800000};
      vecs[3] = '{2, 32'h40400000, 32'h40800000, 32'h40E00000};
      vecs[4] = '{1, 32'h3F000000, 32'h3E800000, 32'h3F400000};
      vecs[5] = '{0, 32'h3F800000, 32'hC0400000, 32'hC0000000};

      rst           = 1'b1;
      forceBusy     = 1'b0;
      forceDone     = 1'b0;
      suppressDone  = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      #12;
      checkResetState("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single requests. Each one is granted on the first edge, fpu_en is
      // high for one cycle, and the response arrives 6 cycles after the
      // request was raised.
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].idx, vecs[v].a, vecs[v].b);
         @(negedge clk);
         checkOutput($sformatf("v%0d_fpu_en", v),   32'(bus.fpu_en),   32'd1);
         checkOutput($sformatf("v%0d_grant", v),    32'(bus.grant_id), 32'(vecs[v].idx));
         checkOutput($sformatf("v%0d_fpu_a", v),    bus.fpu_a,         vecs[v].a);
         checkOutput($sformatf("v%0d_fpu_b", v),    bus.fpu_b,         vecs[v].b);
         checkOutput($sformatf("v%0d_arb_busy", v), 32'(bus.arb_busy), 32'd1);
         @(negedge clk);
         checkOutput($sformatf("v%0d_fpu_en_off", v), 32'(bus.fpu_en), 32'd0);
         waitRsp(20, cyc);
         checkOutput($sformatf("v%0d_latency", v),   32'(cyc + 2),       32'd6);
         checkOutput($sformatf("v%0d_rsp_valid", v), 32'(bus.rsp_valid), 32'(4'(1) << vecs[v].idx));
         checkOutput($sformatf("v%0d_rsp_data", v),  bus.rsp_data,        vecs[v].expData);
         checkOutput($sformatf("v%0d_rsp_err", v),   32'(bus.rsp_err),    32'd0);
         bus.req_valid[vecs[v].idx] = 1'b0;
         @(negedge clk);
         checkOutput($sformatf("v%0d_rsp_drop", v), 32'(bus.rsp_valid), 32'd0);
         checkOutput($sformatf("v%0d_data_hold", v), bus.rsp_data,      vecs[v].expData);
         checkOutput($sformatf("v%0d_idle", v),     32'(bus.arb_busy),  32'd0);
      end

      // All four requesters at once. After reset they are served in order
      // 0,1,2,3 and the responses are spaced 7 cycles apart.
      doReset();
      opA    = '{32'h41200000, 32'h3F800000, 32'h40400000, 32'h3F000000};
      opB    = '{32'h40C00000, 32'h40000000, 32'h40800000, 32'h3E800000};
      expSum = '{32'h41800000, 32'h40400000, 32'h40E00000, 32'h3F400000};
      for (int i = 0; i < 4; i++) applyStimulus(i, opA[i], opB[i]);
      for (int k = 0; k < 4; k++) begin
         waitRsp(30, cyc);
         checkOutput($sformatf("rr%0d_spacing", k),   32'(cyc),            (k == 0) ? 32'd6 : 32'd7);
         checkOutput($sformatf("rr%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'(4'(1) << k));
         checkOutput($sformatf("rr%0d_rsp_data", k),  bus.rsp_data,        expSum[k]);
         bus.req_valid[k] = 1'b0;
      end
      @(negedge clk);

      // Requester 0 re-requests immediately while requester 2 is pending,
      // giving the order 0, 2, 0. Requester 3 is raised after that second
      // grant to 0, so it is served last.
      doReset();
      applyStimulus(0, 32'h3F800000, 32'h40000000);
      applyStimulus(2, 32'h40000000, 32'h40000000);
      waitRsp(20, cyc);
      checkOutput("rr2_first_valid", 32'(bus.rsp_valid), 32'h1);
      checkOutput("rr2_first_data",  bus.rsp_data,       32'h40400000);
      applyStimulus(0, 32'h3FC00000, 32'h40200000);
      waitRsp(20, cyc);
      checkOutput("rr2_second_valid", 32'(bus.rsp_valid), 32'h4);
      checkOutput("rr2_second_data",  bus.rsp_data,       32'h40800000);
      bus.req_valid[2] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rr2_third_grant", 32'(bus.grant_id), 32'd0);
      checkOutput("rr2_third_fpu_a", bus.fpu_a,         32'h3FC00000);
      applyStimulus(3, 32'h40400000, 32'h40800000);
      waitRsp(20, cyc);
      checkOutput("rr2_third_valid", 32'(bus.rsp_valid), 32'h1);
      checkOutput("rr2_third_data",  bus.rsp_data,       32'h40800000);
      bus.req_valid[0] = 1'b0;
      waitRsp(20, cyc);
      checkOutput("rr2_fourth_valid", 32'(bus.rsp_valid), 32'h8);
      checkOutput("rr2_fourth_data",  bus.rsp_data,       32'h40E00000);
      bus.req_valid[3] = 1'b0;
      @(negedge clk);

      // Watchdog: done never arrives. The error response comes after E17,
      // and a late done pulse produces nothing.
      suppressDone = 1'b1;
      applyStimulus(2, 32'h3F800000, 32'h40000000);
      waitRsp(40, cyc);
      checkOutput("to_latency",   32'(cyc),            32'd18);
      checkOutput("to_rsp_valid", 32'(bus.rsp_valid), 32'h4);
      checkOutput("to_rsp_err",   32'(bus.rsp_err),   32'd1);
      checkOutput("to_rsp_data",  bus.rsp_data,        32'd0);
      bus.req_valid[2] = 1'b0;
      suppressDone = 1'b0;
      @(negedge clk);
      forceDone = 1'b1;
      @(negedge clk);
      forceDone = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.rsp_valid != '0 || bus.arb_busy) ok = 1'b0;
      end
      checkOutput("late_done_ignored", 32'(ok),     32'd1);
      checkOutput("late_done_data",    bus.rsp_data, 32'd0);

      // While fpu_busy is high there is no grant. The grant comes on the
      // first edge after it drops.
      forceBusy = 1'b1;
      applyStimulus(1, 32'h40000000, 32'h40000000);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.fpu_en || bus.arb_busy) ok = 1'b0;
      end
      checkOutput("busy_no_grant", 32'(ok), 32'd1);
      forceBusy = 1'b0;
      @(negedge clk);
      checkOutput("busy_release_en",    32'(bus.fpu_en),   32'd1);
      checkOutput("busy_release_grant", 32'(bus.grant_id), 32'd1);
      waitRsp(20, cyc);
      checkOutput("busy_rsp_data", bus.rsp_data, 32'h40800000);
      bus.req_valid[1] = 1'b0;
      @(negedge clk);

      // Reset in the middle of WAIT. All outputs clear asynchronously, and
      // afterwards requester 0 beats requester 1.
      applyStimulus(3, 32'h3F800000, 32'h40000000);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      bus.req_valid = '0;
      #1;
      checkResetState("midwait");
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 32'h3F800000, 32'hC0400000);
      applyStimulus(1, 32'h3F000000, 32'h3E800000);
      @(negedge clk);
      checkOutput("post_reset_grant", 32'(bus.grant_id), 32'd0);
      waitRsp(20, cyc);
      checkOutput("post_reset_rsp0", bus.rsp_data, 32'hC0000000);
      bus.req_valid[0] = 1'b0;
      waitRsp(20, cyc);
      checkOutput("post_reset_rsp1_valid", 32'(bus.rsp_valid), 32'h2);
      checkOutput("post_reset_rsp1", bus.rsp_data, 32'h3F400000);
      bus.req_valid[1] = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
